// File: rtl/mips_multicycle_ctrl_if.sv
// Instruction memory, data memory, register file and ALU connections of the Mini-MIPS multicycle controller.
interface mips_multicycle_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [4:0]  rf_raddr1;
  logic [4:0]  rf_raddr2;
  logic [31:0] rf_rdata1;
  logic [31:0] rf_rdata2;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [5:0]  alu_op_code;
  logic [5:0]  alu_func;
  logic [31:0] alu_regin1;
  logic [31:0] alu_regin2;
  logic [31:0] alu_regout;
  logic        alu_zero;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output imem_req, imem_addr, rf_raddr1, rf_raddr2, rf_we, rf_waddr, rf_wdata,
           alu_op_code, alu_func, alu_regin1, alu_regin2,
           dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  imem_rdata, imem_ack, rf_rdata1, rf_rdata2, alu_regout, alu_zero,
           dmem_rdata, dmem_ack
  );

  modport slave (
    input  imem_req, imem_addr, rf_raddr1, rf_raddr2, rf_we, rf_waddr, rf_wdata,
           alu_op_code, alu_func, alu_regin1, alu_regin2,
           dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output imem_rdata, imem_ack, rf_rdata1, rf_rdata2, alu_regout, alu_zero,
           dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer for the Mini-MIPS core.
// Optional macro ILLEGAL_TRAP_EN: unsupported instructions set the sticky illegal flag and halt.
module mips_multicycle_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [5:0]  HALT_OPCODE = 6'd63
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  mips_multicycle_ctrl_if.master        bus,
  output logic [31:0]                   pc,
  output logic                          busy,
  output logic                          halted,
  output logic                          illegal
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned OPW  = 6;
  localparam int unsigned RAW  = 5;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t          state;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] b_q;

  logic [OPW-1:0]  op;
  logic [OPW-1:0]  fn;
  logic            is_rtype, is_shift, rfunc_ok, is_imm_op, is_lui;
  logic            is_branch, is_jump, is_lw, is_sw, is_halt, legal, wr_en;
  logic [RAW-1:0]  waddr;
  logic [XLEN-1:0] imm, pc_plus4, br_target, j_target;

  assign bus.imem_addr = pc;
  assign bus.rf_raddr1 = instr[25:21];
  assign bus.rf_raddr2 = instr[20:16];

  // Instruction classification from the latched instruction word
  always_comb begin
    op        = instr[31:26];
    fn        = instr[5:0];
    is_rtype  = (op == 6'd0);
    is_shift  = is_rtype && (fn inside {6'd0, 6'd2, 6'd3, 6'd4});
    rfunc_ok  = fn inside {6'd0, 6'd2, 6'd3, 6'd4, [6'd32:6'd39], 6'd42, 6'd43};
    is_imm_op = op inside {6'd8, 6'd9, 6'd10, 6'd12, 6'd13, 6'd14, 6'd15, 6'd35, 6'd43};
    is_lui    = (op == 6'd36);
    is_branch = (op == 6'd41) || (op inside {[6'd48:6'd54]});
    is_jump   = (op == 6'd2);
    is_lw     = (op == 6'd35);
    is_sw     = (op == 6'd43);
    is_halt   = (op == HALT_OPCODE);
    legal     = (is_rtype && rfunc_ok) || is_imm_op || is_lui || is_branch || is_jump || is_halt;
    waddr     = is_rtype ? instr[15:11] : instr[20:16];
    wr_en     = legal && (is_rtype || (is_imm_op && !is_sw) || is_lui) && (waddr != 5'd0);
    imm       = (op inside {6'd13, 6'd14, 6'd15}) ? {16'b0, instr[15:0]}
                                                  : {{16{instr[15]}}, instr[15:0]};
    pc_plus4  = pc + 32'd4;
    br_target = pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00};
    j_target  = {pc_plus4[31:28], instr[25:0], 2'b00};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      pc              <= RESET_PC;
      instr           <= '0;
      b_q             <= '0;
      busy            <= 1'b0;
      halted          <= 1'b0;
      illegal         <= 1'b0;
      bus.imem_req    <= 1'b0;
      bus.rf_we       <= 1'b0;
      bus.rf_waddr    <= '0;
      bus.rf_wdata    <= '0;
      bus.alu_op_code <= '0;
      bus.alu_func    <= '0;
      bus.alu_regin1  <= '0;
      bus.alu_regin2  <= '0;
      bus.dmem_req    <= 1'b0;
      bus.dmem_we     <= 1'b0;
      bus.dmem_addr   <= '0;
      bus.dmem_wdata  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state        <= S_FETCH;
            bus.imem_req <= 1'b1;
            busy         <= 1'b1;
          end
        end

        S_FETCH: begin
          if (bus.imem_ack) begin
            instr        <= bus.imem_rdata;
            bus.imem_req <= 1'b0;
            state        <= S_DECODE;
          end
        end

        S_DECODE: begin
          b_q <= bus.rf_rdata2;
          if (is_halt) begin
            state  <= S_HALT;
            busy   <= 1'b0;
            halted <= 1'b1;
`ifdef ILLEGAL_TRAP_EN
          end else if (!legal) begin
            state   <= S_HALT;
            busy    <= 1'b0;
            halted  <= 1'b1;
            illegal <= 1'b1;
`endif
          end else begin
            state <= S_EXEC;
            // Jumps and unsupported words park the ALU on its zero-output function
            if (is_jump || !legal) begin
              bus.alu_op_code <= 6'd0;
              bus.alu_func    <= 6'd63;
              bus.alu_regin1  <= '0;
              bus.alu_regin2  <= '0;
            end else begin
              bus.alu_op_code <= op;
              bus.alu_func    <= fn;
              if (is_shift) begin
                bus.alu_regin1 <= bus.rf_rdata2;
                bus.alu_regin2 <= {16'b0, instr[15:0]};
              end else if (is_rtype || is_branch) begin
                bus.alu_regin1 <= bus.rf_rdata1;
                bus.alu_regin2 <= bus.rf_rdata2;
              end else begin
                bus.alu_regin1 <= bus.rf_rdata1;
                bus.alu_regin2 <= imm;
              end
            end
          end
        end

        S_EXEC: begin
          if (is_lw || is_sw) begin
            state          <= S_MEM;
            bus.dmem_req   <= 1'b1;
            bus.dmem_we    <= is_sw;
            bus.dmem_addr  <= bus.alu_regout;
            bus.dmem_wdata <= b_q;
          end else if (is_branch || is_jump) begin
            state        <= S_FETCH;
            bus.imem_req <= 1'b1;
            pc           <= is_jump ? j_target : (bus.alu_zero ? br_target : pc_plus4);
          end else begin
            state        <= S_WB;
            bus.rf_we    <= wr_en;
            bus.rf_waddr <= waddr;
            bus.rf_wdata <= bus.alu_regout;
          end
        end

        S_MEM: begin
          if (bus.dmem_ack) begin
            bus.dmem_req <= 1'b0;
            bus.dmem_we  <= 1'b0;
            if (is_lw) begin
              state        <= S_WB;
              bus.rf_we    <= (waddr != 5'd0);
              bus.rf_waddr <= waddr;
              bus.rf_wdata <= bus.dmem_rdata;
            end else begin
              state        <= S_FETCH;
              bus.imem_req <= 1'b1;
              pc           <= pc_plus4;
            end
          end
        end

        S_WB: begin
          bus.rf_we    <= 1'b0;
          pc           <= pc_plus4;
          state        <= S_FETCH;
          bus.imem_req <= 1'b1;
        end

        S_HALT: state <= S_HALT;

        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: runs a short program through stub memories, register file and ALU.
module tb_mips_multicycle_ctrl;
  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] pc;
  logic        busy;
  logic        halted;
  logic        illegal;

  int n_tests = 0;
  int n_fail  = 0;

  mips_multicycle_ctrl_if bus ();

  mips_multicycle_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus),
    .pc(pc), .busy(busy), .halted(halted), .illegal(illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Environment stubs: memories with programmable ack delay, register file, add/compare ALU
  logic [31:0] imem [64];
  logic [31:0] rf   [32];
  logic [31:0] dmem_word;
  int          imem_delay = 0;
  int          dmem_delay = 0;
  int          imem_cnt   = 0;
  int          dmem_cnt   = 0;
  logic        dmem_force = 1'b0;

  always @(posedge clk) begin
    if (!bus.imem_req || bus.imem_ack) imem_cnt <= 0;
    else                               imem_cnt <= imem_cnt + 1;
    if (!bus.dmem_req || bus.dmem_ack) dmem_cnt <= 0;
    else                               dmem_cnt <= dmem_cnt + 1;
  end

  assign bus.imem_ack   = bus.imem_req && (imem_cnt >= imem_delay);
  assign bus.imem_rdata = imem[6'(bus.imem_addr >> 2)];
  assign bus.rf_rdata1  = rf[bus.rf_raddr1];
  assign bus.rf_rdata2  = rf[bus.rf_raddr2];
  assign bus.alu_regout = bus.alu_regin1 + bus.alu_regin2;
  assign bus.alu_zero   = (bus.alu_regin1 == bus.alu_regin2);
  assign bus.dmem_ack   = (bus.dmem_req && (dmem_cnt >= dmem_delay)) || dmem_force;
  assign bus.dmem_rdata = dmem_word;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    step(); step();
    n_tests++;
    if (pc !== 32'h0 || busy !== 1'b0 || halted !== 1'b0 || illegal !== 1'b0) begin
      n_fail++; $display("FAIL reset_status: pc=%h busy=%b halted=%b illegal=%b want 0/0/0/0", pc, busy, halted, illegal);
    end
    n_tests++;
    if (bus.imem_req !== 1'b0 || bus.dmem_req !== 1'b0 || bus.rf_we !== 1'b0) begin
      n_fail++; $display("FAIL reset_strobes: imem_req=%b dmem_req=%b rf_we=%b want 0", bus.imem_req, bus.dmem_req, bus.rf_we);
    end
    rst = 1'b0;
    step(); step();
    n_tests++;
    if (bus.imem_req !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_wait: imem_req=%b busy=%b want 0/0", bus.imem_req, busy);
    end
  endtask

  task automatic test_addi();
    start = 1'b1; step(); start = 1'b0;
    n_tests++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL addi_fetch: req=%b addr=%h busy=%b want 1/0/1", bus.imem_req, bus.imem_addr, busy);
    end
    step();
    n_tests++;
    if (bus.rf_raddr1 !== 5'd0 || bus.rf_raddr2 !== 5'd8 || bus.imem_req !== 1'b0) begin
      n_fail++; $display("FAIL addi_decode: rs=%0d rt=%0d req=%b want 0/8/0", bus.rf_raddr1, bus.rf_raddr2, bus.imem_req);
    end
    step();
    n_tests++;
    if (bus.alu_op_code !== 6'd8 || bus.alu_regin1 !== 32'd0 || bus.alu_regin2 !== 32'd5) begin
      n_fail++; $display("FAIL addi_exec: op=%0d r1=%h r2=%h want 8/0/5", bus.alu_op_code, bus.alu_regin1, bus.alu_regin2);
    end
    step();
    n_tests++;
    if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd8 || bus.rf_wdata !== 32'd5 || pc !== 32'h0) begin
      n_fail++; $display("FAIL addi_wb: we=%b waddr=%0d wdata=%h pc=%h want 1/8/5/0", bus.rf_we, bus.rf_waddr, bus.rf_wdata, pc);
    end
    step();
    n_tests++;
    if (pc !== 32'h4 || bus.imem_req !== 1'b1 || bus.rf_we !== 1'b0) begin
      n_fail++; $display("FAIL addi_next: pc=%h req=%b we=%b want 4/1/0", pc, bus.imem_req, bus.rf_we);
    end
  endtask

  task automatic test_add();
    start = 1'b1;
    step();
    n_tests++;
    if (bus.rf_raddr1 !== 5'd8 || bus.rf_raddr2 !== 5'd9) begin
      n_fail++; $display("FAIL add_decode: rs=%0d rt=%0d want 8/9", bus.rf_raddr1, bus.rf_raddr2);
    end
    step(); start = 1'b0;
    n_tests++;
    if (bus.alu_op_code !== 6'd0 || bus.alu_func !== 6'd32 || bus.alu_regin1 !== 32'd5 || bus.alu_regin2 !== 32'd7) begin
      n_fail++; $display("FAIL add_exec: op=%0d fn=%0d r1=%h r2=%h want 0/32/5/7", bus.alu_op_code, bus.alu_func, bus.alu_regin1, bus.alu_regin2);
    end
    step();
    n_tests++;
    if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd10 || bus.rf_wdata !== 32'd12) begin
      n_fail++; $display("FAIL add_wb: we=%b waddr=%0d wdata=%h want 1/10/c", bus.rf_we, bus.rf_waddr, bus.rf_wdata);
    end
    step();
    n_tests++;
    if (pc !== 32'h8 || bus.imem_req !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL add_next: pc=%h req=%b busy=%b want 8/1/1", pc, bus.imem_req, busy);
    end
  endtask

  task automatic test_lw_wait();
    int k;
    dmem_delay = 3; dmem_word = 32'hDEAD_BEEF;
    step(); step();
    n_tests++;
    if (bus.alu_op_code !== 6'd35 || bus.alu_regin1 !== 32'h100 || bus.alu_regin2 !== 32'd8) begin
      n_fail++; $display("FAIL lw_exec: op=%0d r1=%h r2=%h want 35/100/8", bus.alu_op_code, bus.alu_regin1, bus.alu_regin2);
    end
    step();
    n_tests++;
    if (bus.dmem_req !== 1'b1 || bus.dmem_we !== 1'b0 || bus.dmem_addr !== 32'h108) begin
      n_fail++; $display("FAIL lw_mem: req=%b we=%b addr=%h want 1/0/108", bus.dmem_req, bus.dmem_we, bus.dmem_addr);
    end
    k = 0;
    while (bus.dmem_req === 1'b1 && k < 20) begin
      k++; step();
    end
    n_tests++;
    if (k !== 4) begin
      n_fail++; $display("FAIL lw_req_cycles: got %0d want 4", k);
    end
    n_tests++;
    if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd4 || bus.rf_wdata !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL lw_wb: we=%b waddr=%0d wdata=%h want 1/4/deadbeef", bus.rf_we, bus.rf_waddr, bus.rf_wdata);
    end
    step();
    n_tests++;
    if (pc !== 32'hC || bus.imem_req !== 1'b1) begin
      n_fail++; $display("FAIL lw_next: pc=%h req=%b want c/1", pc, bus.imem_req);
    end
    dmem_delay = 0;
  endtask

  task automatic test_sw();
    step(); step();
    n_tests++;
    if (bus.alu_op_code !== 6'd43 || bus.alu_regin1 !== 32'h100 || bus.alu_regin2 !== 32'd4) begin
      n_fail++; $display("FAIL sw_exec: op=%0d r1=%h r2=%h want 43/100/4", bus.alu_op_code, bus.alu_regin1, bus.alu_regin2);
    end
    step();
    n_tests++;
    if (bus.dmem_req !== 1'b1 || bus.dmem_we !== 1'b1 || bus.dmem_addr !== 32'h104 ||
        bus.dmem_wdata !== 32'hCAFE_F00D || bus.rf_we !== 1'b0) begin
      n_fail++; $display("FAIL sw_mem: req=%b we=%b addr=%h wdata=%h rf_we=%b want 1/1/104/cafef00d/0",
                         bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.dmem_wdata, bus.rf_we);
    end
    step();
    n_tests++;
    if (pc !== 32'h10 || bus.imem_req !== 1'b1 || bus.dmem_req !== 1'b0) begin
      n_fail++; $display("FAIL sw_next: pc=%h ireq=%b dreq=%b want 10/1/0", pc, bus.imem_req, bus.dmem_req);
    end
  endtask

  task automatic test_shift();
    step(); step();
    n_tests++;
    if (bus.alu_func !== 6'd0 || bus.alu_regin1 !== 32'h100 || bus.alu_regin2 !== 32'h1900) begin
      n_fail++; $display("FAIL sll_exec: fn=%0d r1=%h r2=%h want 0/100/1900", bus.alu_func, bus.alu_regin1, bus.alu_regin2);
    end
    step();
    n_tests++;
    if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd3 || bus.rf_wdata !== 32'h1A00) begin
      n_fail++; $display("FAIL sll_wb: we=%b waddr=%0d wdata=%h want 1/3/1a00", bus.rf_we, bus.rf_waddr, bus.rf_wdata);
    end
    step();
    n_tests++;
    if (pc !== 32'h14) begin
      n_fail++; $display("FAIL sll_next: pc=%h want 14", pc);
    end
  endtask

  task automatic test_jump();
    step(); step();
    n_tests++;
    if (bus.alu_op_code !== 6'd0 || bus.alu_func !== 6'd63 || bus.alu_regin1 !== 32'd0) begin
      n_fail++; $display("FAIL j_exec: op=%0d fn=%0d r1=%h want 0/63/0", bus.alu_op_code, bus.alu_func, bus.alu_regin1);
    end
    step();
    n_tests++;
    if (pc !== 32'h20 || bus.imem_req !== 1'b1 || bus.rf_we !== 1'b0) begin
      n_fail++; $display("FAIL j_next: pc=%h req=%b we=%b want 20/1/0", pc, bus.imem_req, bus.rf_we);
    end
  endtask

  task automatic test_branch();
    logic saw_we;
    saw_we = 1'b0;
    rf[1] = 32'h100;
    step(); saw_we |= bus.rf_we;
    n_tests++;
    if (bus.rf_raddr1 !== 5'd1 || bus.rf_raddr2 !== 5'd2) begin
      n_fail++; $display("FAIL beq_decode: rs=%0d rt=%0d want 1/2", bus.rf_raddr1, bus.rf_raddr2);
    end
    step(); saw_we |= bus.rf_we;
    n_tests++;
    if (bus.alu_op_code !== 6'd41 || bus.alu_regin1 !== 32'h100 || bus.alu_regin2 !== 32'h100) begin
      n_fail++; $display("FAIL beq_exec: op=%0d r1=%h r2=%h want 41/100/100", bus.alu_op_code, bus.alu_regin1, bus.alu_regin2);
    end
    step(); saw_we |= bus.rf_we;
    n_tests++;
    if (pc !== 32'h1C || bus.imem_req !== 1'b1) begin
      n_fail++; $display("FAIL beq_taken: pc=%h req=%b want 1c/1", pc, bus.imem_req);
    end
    rf[1] = 32'h55;
    step(); step(); step(); saw_we |= bus.rf_we;
    n_tests++;
    if (pc !== 32'h20) begin
      n_fail++; $display("FAIL j_back: pc=%h want 20", pc);
    end
    step(); step(); saw_we |= bus.rf_we;
    n_tests++;
    if (bus.alu_regin1 !== 32'h55 || bus.alu_regin2 !== 32'h100) begin
      n_fail++; $display("FAIL beq2_exec: r1=%h r2=%h want 55/100", bus.alu_regin1, bus.alu_regin2);
    end
    step(); saw_we |= bus.rf_we;
    n_tests++;
    if (pc !== 32'h24) begin
      n_fail++; $display("FAIL beq_not_taken: pc=%h want 24", pc);
    end
    n_tests++;
    if (saw_we !== 1'b0) begin
      n_fail++; $display("FAIL branch_no_write: rf_we seen=%b want 0", saw_we);
    end
  endtask

  task automatic test_illegal();
    step(); step();
`ifdef ILLEGAL_TRAP_EN
    n_tests++;
    if (illegal !== 1'b1 || halted !== 1'b1 || busy !== 1'b0 || pc !== 32'h24) begin
      n_fail++; $display("FAIL illegal_trap: ill=%b halted=%b busy=%b pc=%h want 1/1/0/24", illegal, halted, busy, pc);
    end
    step();
    n_tests++;
    if (pc !== 32'h24 || bus.imem_req !== 1'b0) begin
      n_fail++; $display("FAIL illegal_hold: pc=%h req=%b want 24/0", pc, bus.imem_req);
    end
`else
    step();
    n_tests++;
    if (bus.rf_we !== 1'b0 || illegal !== 1'b0) begin
      n_fail++; $display("FAIL illegal_nop_wb: we=%b ill=%b want 0/0", bus.rf_we, illegal);
    end
    step();
    n_tests++;
    if (pc !== 32'h28 || bus.imem_req !== 1'b1 || halted !== 1'b0) begin
      n_fail++; $display("FAIL illegal_nop_next: pc=%h req=%b halted=%b want 28/1/0", pc, bus.imem_req, halted);
    end
`endif
  endtask

  task automatic test_halt();
    rst = 1'b1; step(); rst = 1'b0;
    imem[0] = 32'hFC00_0000;
    start = 1'b1; step(); start = 1'b0;
    step(); step();
    n_tests++;
    if (halted !== 1'b1 || busy !== 1'b0 || pc !== 32'h0 || illegal !== 1'b0) begin
      n_fail++; $display("FAIL halt_enter: halted=%b busy=%b pc=%h ill=%b want 1/0/0/0", halted, busy, pc, illegal);
    end
    start = 1'b1; step(); step(); start = 1'b0;
    n_tests++;
    if (halted !== 1'b1 || bus.imem_req !== 1'b0 || pc !== 32'h0) begin
      n_fail++; $display("FAIL halt_absorb: halted=%b req=%b pc=%h want 1/0/0", halted, bus.imem_req, pc);
    end
  endtask

  task automatic test_reset_mid_mem();
    rst = 1'b1; step(); rst = 1'b0;
    imem[0] = 32'h8C44_0008;
    dmem_delay = 10;
    start = 1'b1; step(); start = 1'b0;
    step(); step(); step(); step();
    n_tests++;
    if (bus.dmem_req !== 1'b1 || halted !== 1'b0) begin
      n_fail++; $display("FAIL rst_setup: dreq=%b halted=%b want 1/0", bus.dmem_req, halted);
    end
    rst = 1'b1; step(); rst = 1'b0;
    n_tests++;
    if (bus.dmem_req !== 1'b0 || busy !== 1'b0 || pc !== 32'h0 || bus.imem_req !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_mem: dreq=%b busy=%b pc=%h ireq=%b want 0/0/0/0", bus.dmem_req, busy, pc, bus.imem_req);
    end
    dmem_force = 1'b1; step(); dmem_force = 1'b0; step();
    n_tests++;
    if (bus.rf_we !== 1'b0 || busy !== 1'b0 || bus.imem_req !== 1'b0 || bus.dmem_req !== 1'b0) begin
      n_fail++; $display("FAIL late_ack: we=%b busy=%b ireq=%b dreq=%b want 0/0/0/0", bus.rf_we, busy, bus.imem_req, bus.dmem_req);
    end
    dmem_delay = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; dmem_word = 32'h0;
    for (int i = 0; i < 64; i++) imem[i] = 32'h0;
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    imem[0]  = 32'h2008_0005;  // addi $8,$0,5
    imem[1]  = 32'h0109_5020;  // add  $10,$8,$9
    imem[2]  = 32'h8C44_0008;  // lw   $4,8($2)
    imem[3]  = 32'hAC45_0004;  // sw   $5,4($2)
    imem[4]  = 32'h0002_1900;  // sll  $3,$2,4
    imem[5]  = 32'h0800_0008;  // j    0x20
    imem[7]  = 32'h0800_0008;  // j    0x20
    imem[8]  = 32'hA422_FFFE;  // beq  $1,$2,-2
    imem[9]  = 32'h5000_0000;  // opcode 20
    imem[10] = 32'hFC00_0000;  // halt
    rf[2] = 32'h100; rf[5] = 32'hCAFE_F00D; rf[8] = 32'd5; rf[9] = 32'd7;

    test_reset();
    test_addi();
    test_add();
    test_lw_wait();
    test_sw();
    test_shift();
    test_jump();
    test_branch();
    test_illegal();
    test_halt();
    test_reset_mid_mem();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
